// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output capture block:
// default widths, FSM state encoding and the frame-length check.
package fft_pkg;

    localparam int FFT_ADDR_WIDTH = 10;
    localparam int FFT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    // A frame is well formed only when s_last lands exactly on the
    // final buffer slot; any other combination flags a length error.
    function automatic logic frame_mismatch(
        input logic last,
        input logic at_end
    );
        return last != at_end;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered
// read port. Reads return the old word on a same-address write.
module capture_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; NBA ordering gives read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_out_capture.sv
// Captures one FFT output frame into a buffer on request and
// reports completion, beat count and frame-length errors.
module fft_out_capture
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX =
        (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] FULL_CNT =
        (ADDR_WIDTH+1)'(DEPTH);

    cap_state_e state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic accept;
    logic at_end;

    // Next-state, counter and error decode; arm is only seen
    // outside CAPTURE so a pulse mid-frame cannot restart it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        accept  = 1'b0;
        at_end  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (s_valid) begin
                    accept = 1'b1;
                    at_end = (cnt_q == LAST_IDX);
                    if (cnt_q != FULL_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (s_last || at_end) begin
                        state_d = ST_DONE;
                        err_d   = frame_mismatch(s_last, at_end);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // State and status registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    capture_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we_i   (accept),
        .waddr_i(cnt_q[ADDR_WIDTH-1:0]),
        .wdata_i(s_data),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    assign s_ready   = (state_q == ST_CAPTURE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;
    assign wr_count  = cnt_q;

endmodule

// File: tb/tb_fft_out_capture.sv
// Scoreboard bench for fft_out_capture with a 16-entry frame.
// Reads are queued at drive time and compared at the output.
module tb_fft_out_capture;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          frame_err;
    logic [AW:0]   wr_count;

    int n_checks;
    int n_fail;

    int            m_state;
    int            m_cnt;
    logic          m_err;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] rdq [$];

    fft_out_capture #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare outputs.
    task automatic step(
        input string         tag,
        input logic          a,
        input logic          v,
        input logic [DW-1:0] d,
        input logic          l,
        input logic          rchk,
        input logic [AW-1:0] ra
    );
        logic [DW-1:0] got;
        logic          term;
        logic          at_end;
        arm     = a;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        rd_addr = ra;
        check_eq({tag, "_rdy"}, 64'(s_ready), 64'(m_state == 1));
        if (rchk) rdq.push_back(mem_m[ra]);
        if (m_state == 1) begin
            if (v) begin
                mem_m[m_cnt] = d;
                at_end = (m_cnt == DEPTH - 1);
                term = l || at_end;
                if (term) begin
                    m_err = (l != at_end);
                    m_state = 2;
                end
                if (m_cnt < DEPTH) m_cnt++;
            end
        end else if (a) begin
            m_state = 1;
            m_cnt = 0;
            m_err = 1'b0;
        end
        @(posedge clk);
        #1;
        arm     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (rchk) begin
            if (rdq.size() == 0) begin
                check_eq({tag, "_rdq"}, 64'd0, 64'd1);
            end else begin
                got = rdq.pop_front();
                check_eq({tag, "_rd"}, 64'(rd_data), 64'(got));
            end
        end
        check_eq({tag, "_busy"}, 64'(busy), 64'(m_state == 1));
        check_eq({tag, "_done"}, 64'(done), 64'(m_state == 2));
        check_eq({tag, "_err"}, 64'(frame_err), 64'(m_err));
        check_eq({tag, "_cnt"}, 64'(wr_count), 64'(m_cnt));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic beat(
        input string         tag,
        input logic [DW-1:0] d,
        input logic          l
    );
        step(tag, 1'b0, 1'b1, d, l, 1'b0, '0);
    endtask

    task automatic do_arm(input string tag);
        step(tag, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(i));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        m_state = 0;
        m_cnt = 0;
        m_err = 1'b0;
        arm = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        rd_addr = '0;
        rst = 1'b1;
        #12;
        check_eq("rst_state_ready", 64'(s_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(frame_err), 64'd0);
        check_eq("rst_cnt", 64'(wr_count), 64'd0);
        check_eq("rst_rd", 64'(rd_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("t0_idle");

        // Full well-formed frame
        do_arm("t1_arm");
        for (int i = 0; i < DEPTH; i++) begin
            beat("t1_beat", DW'(i), i == DEPTH - 1);
        end
        check_eq("t1_done", 64'(done), 64'd1);
        check_eq("t1_err", 64'(frame_err), 64'd0);
        check_eq("t1_cnt", 64'(wr_count), 64'd16);
        read_all("t1_read");

        // Short frame: upper slots keep prior data
        do_arm("t2_arm");
        for (int i = 0; i < 10; i++) begin
            beat("t2_beat", DW'(32'h100 + i), i == 9);
        end
        check_eq("t2_err", 64'(frame_err), 64'd1);
        check_eq("t2_cnt", 64'(wr_count), 64'd10);
        read_all("t2_read");

        // Missing s_last, then an extra beat that must be dropped
        do_arm("t3_arm");
        for (int i = 0; i < DEPTH; i++) begin
            beat("t3_beat", DW'(32'h200 + i), 1'b0);
        end
        check_eq("t3_done", 64'(done), 64'd1);
        check_eq("t3_err", 64'(frame_err), 64'd1);
        beat("t3_extra", 32'hBAD0BAD0, 1'b0);
        check_eq("t3_cnt", 64'(wr_count), 64'd16);
        read_all("t3_read");

        // Gapped beats and a stray arm on beat 5
        do_arm("t4_arm");
        for (int i = 0; i < DEPTH; i++) begin
            step("t4_beat", i == 5, 1'b1, DW'(32'h300 + i),
                 i == DEPTH - 1, 1'b0, '0);
            if (i < DEPTH - 1) begin
                for (int g = 0; g < 3; g++) idle("t4_gap");
            end
        end
        check_eq("t4_err", 64'(frame_err), 64'd0);
        read_all("t4_read");

        // Reset mid-capture, then recapture
        do_arm("t5_arm");
        for (int i = 0; i < 8; i++) begin
            beat("t5_beat", DW'(32'h4F0 + i), 1'b0);
        end
        rst = 1'b1;
        #1;
        check_eq("t5_rst_cnt", 64'(wr_count), 64'd0);
        check_eq("t5_rst_rdy", 64'(s_ready), 64'd0);
        check_eq("t5_rst_busy", 64'(busy), 64'd0);
        m_state = 0;
        m_cnt = 0;
        m_err = 1'b0;
        rdq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("t5_idle");
        do_arm("t5_rearm");
        for (int i = 0; i < DEPTH; i++) begin
            beat("t5_full", DW'(32'h400 + i), i == DEPTH - 1);
        end
        read_all("t5_read");

        // Same-cycle read and write of address 3
        do_arm("t6_arm");
        for (int i = 0; i < 3; i++) begin
            beat("t6_beat", DW'(32'h500 + i), 1'b0);
        end
        step("t6_rbw", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 4'd3);
        check_eq("t6_old", 64'(rd_data), 64'h403);
        step("t6_new", 1'b0, 1'b0, '0, 1'b0, 1'b1, 4'd3);
        check_eq("t6_dbf", 64'(rd_data), 64'hDEADBEEF);
        for (int i = 4; i < DEPTH; i++) begin
            beat("t6_tail", DW'(32'h500 + i), i == DEPTH - 1);
        end
        read_all("t6_read");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
